// File: rtl/sig_mult_seq_if.sv
// ---------------------------------------------------------------------------
// sig_mult_seq_if
// Request/result bundle for the sequential significand multiplier.
//   start   : request strobe (requester -> multiplier)
//   a, b    : WIDTH-bit unsigned significands (requester -> multiplier)
//   busy    : operation in flight (multiplier -> requester)
//   done    : one-cycle completion pulse (multiplier -> requester)
//   product : 2*WIDTH-bit registered product (multiplier -> requester)
// ---------------------------------------------------------------------------
interface sig_mult_seq_if #(
    parameter int WIDTH = 24
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/sig_mult_seq.sv
// ---------------------------------------------------------------------------
// sig_mult_seq
// Sequential unsigned significand multiplier. Radix-2 shift-and-add, one
// partial product per clock, accumulated in carry-save form and resolved by a
// single carry-propagate add at the end. Fixed latency of WIDTH+1 edges from
// the accepting edge to the edge that raises done.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears all state
//   bus     : sig_mult_seq_if.slave (start, a, b in; busy, done, product out)
// ---------------------------------------------------------------------------
module sig_mult_seq #(
    parameter int WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    sig_mult_seq_if.slave   bus
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [PW-1:0]      sum_q;
    logic [PW-1:0]      carry_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      product_q;
    logic               done_q;

    logic               load;
    logic               accum;
    logic               resolve;

    logic [WIDTH-1:0]   b_shr;
    logic [PW-1:0]      pp;
    logic [2*PW-1:0]    csa_out;

    // 3:2 compressor across the full accumulator width. Upper half of the
    // result is the new sum, lower half the new carry (already shifted into
    // its weight). The carry shifted out of the top bit is dropped: the true
    // product always fits in PW bits, so the modulo-2^PW sum stays exact.
    function automatic logic [2*PW-1:0] csa32(
        input logic [PW-1:0] x,
        input logic [PW-1:0] y,
        input logic [PW-1:0] z
    );
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        s = x ^ y ^ z;
        c = (x & y) | (x & z) | (y & z);
        return {s, c << 1};
    endfunction

    // Current multiplier bit selected by the counter, and the matching
    // shifted partial product.
    always_comb begin
        b_shr   = b_q >> cnt_q;
        pp      = (PW'(a_q) & {PW{b_shr[0]}}) << cnt_q;
        csa_out = csa32(sum_q, carry_q, pp);
    end

    // ---- control: state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- control: next state and datapath enables ----
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accum   = 1'b0;
        resolve = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                accum = 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                resolve = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---- datapath: operand capture, carry-save accumulation, resolve ----
    // Operands are only written on the accepting edge, so anything on a/b or
    // start while an operation is in flight cannot reach the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                sum_q   <= '0;
                carry_q <= '0;
                cnt_q   <= '0;
            end
            if (accum) begin
                sum_q   <= csa_out[2*PW-1:PW];
                carry_q <= csa_out[PW-1:0];
                cnt_q   <= cnt_q + CW'(1);
            end
            if (resolve) begin
                product_q <= sum_q + carry_q;
                done_q    <= 1'b1;
            end
        end
    end

    // busy covers ACCUM and RESOLVE; it drops on the same edge that raises
    // done, so the done cycle is already able to accept the next start.
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_sig_mult_seq.sv
module tb_sig_mult_seq;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   cyc;

    sig_mult_seq_if #(.WIDTH(24)) bus24 ();
    sig_mult_seq_if #(.WIDTH(11)) bus11 ();
    sig_mult_seq_if #(.WIDTH(4))  bus4  ();

    sig_mult_seq #(.WIDTH(24)) dut24 (.clk(clk), .rst_n(rst_n), .bus(bus24));
    sig_mult_seq #(.WIDTH(11)) dut11 (.clk(clk), .rst_n(rst_n), .bus(bus11));
    sig_mult_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation on the 24-bit unit; lat counts edges after the accept edge
    // until done is seen, busy_n counts sampled cycles with busy high.
    task automatic op24(input logic [23:0] a, input logic [23:0] b,
                        output logic [63:0] p, output int lat, output int busy_n);
        busy_n = 0;
        @(negedge clk);
        bus24.start = 1'b1; bus24.a = a; bus24.b = b;
        @(posedge clk);
        @(negedge clk);
        bus24.start = 1'b0;
        lat = 0;
        while (!bus24.done && lat < 100) begin
            if (bus24.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        p = 64'(bus24.product);
    endtask

    task automatic op11(input logic [10:0] a, input logic [10:0] b,
                        output logic [63:0] p, output int lat);
        @(negedge clk);
        bus11.start = 1'b1; bus11.a = a; bus11.b = b;
        @(posedge clk);
        @(negedge clk);
        bus11.start = 1'b0;
        lat = 0;
        while (!bus11.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p = 64'(bus11.product);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       output logic [63:0] p, output int lat);
        @(negedge clk);
        bus4.start = 1'b1; bus4.a = a; bus4.b = b;
        @(posedge clk);
        @(negedge clk);
        bus4.start = 1'b0;
        lat = 0;
        while (!bus4.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        p = 64'(bus4.product);
    endtask

    task automatic rand24(input int n);
        logic [23:0] ra, rb;
        logic [63:0] p;
        int lat, bn;
        for (int i = 0; i < n; i++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            if ($urandom_range(7) == 0) ra = 24'hFFFFFF;
            if ($urandom_range(7) == 0) rb = 24'hFFFFFF;
            op24(ra, rb, p, lat, bn);
            check("rand24_prod", p, 64'(ra) * 64'(rb));
            check("rand24_lat", 64'(lat), 64'd25);
        end
    endtask

    task automatic rand11(input int n);
        logic [10:0] ra, rb;
        logic [63:0] p;
        int lat;
        for (int i = 0; i < n; i++) begin
            ra = 11'($urandom);
            rb = 11'($urandom);
            if ($urandom_range(7) == 0) ra = 11'h7FF;
            if ($urandom_range(7) == 0) rb = 11'h7FF;
            op11(ra, rb, p, lat);
            check("rand11_prod", p, 64'(ra) * 64'(rb));
            check("rand11_lat", 64'(lat), 64'd12);
        end
    endtask

    task automatic rand4(input int n);
        logic [3:0] ra, rb;
        logic [63:0] p;
        int lat;
        for (int i = 0; i < n; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            op4(ra, rb, p, lat);
            check("rand4_prod", p, 64'(ra) * 64'(rb));
            check("rand4_lat", 64'(lat), 64'd5);
        end
    endtask

    initial begin
        logic [63:0] p;
        logic [63:0] prev;
        logic [23:0] qa [3];
        logic [23:0] qb [3];
        int lat, bn, guard, dn;
        int t_done [3];

        n_tests = 0;
        n_fail  = 0;
        bus24.start = 1'b0; bus24.a = '0; bus24.b = '0;
        bus11.start = 1'b0; bus11.a = '0; bus11.b = '0;
        bus4.start  = 1'b0; bus4.a  = '0; bus4.b  = '0;
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus24.busy), 64'd0);
        check("rst_done", 64'(bus24.done), 64'd0);
        check("rst_product", 64'(bus24.product), 64'd0);
        rst_n = 1'b1;

        // All-ones operands: full-width result, latency and busy window
        op24(24'hFFFFFF, 24'hFFFFFF, p, lat, bn);
        check("ones_prod", p, 64'hFFFFFE000001);
        check("ones_lat", 64'(lat), 64'd25);
        check("ones_busy_cycles", 64'(bn), 64'd25);
        check("ones_busy_at_done", 64'(bus24.busy), 64'd0);
        @(negedge clk);
        check("ones_done_width", 64'(bus24.done), 64'd0);
        check("ones_prod_hold", 64'(bus24.product), 64'hFFFFFE000001);

        // Single-bit operands, then zero operand with no early exit
        op24(24'h800000, 24'h800000, p, lat, bn);
        check("msb_prod", p, 64'h400000000000);
        op24(24'h000000, 24'hABCDEF, p, lat, bn);
        check("zero_prod", p, 64'd0);
        check("zero_lat", 64'(lat), 64'd25);

        // Start held high for three back-to-back operations
        qa[0] = 24'h123456; qb[0] = 24'h654321;
        qa[1] = 24'h800001; qb[1] = 24'h800001;
        qa[2] = 24'h000001; qb[2] = 24'h000001;
        @(negedge clk);
        bus24.start = 1'b1; bus24.a = qa[0]; bus24.b = qb[0];
        @(posedge clk);
        @(negedge clk);
        bus24.a = qa[1]; bus24.b = qb[1];
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!bus24.done && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            t_done[k] = cyc;
            check($sformatf("b2b_prod%0d", k), 64'(bus24.product), 64'(qa[k]) * 64'(qb[k]));
            @(negedge clk);
            if (k == 0) begin
                bus24.a = qa[2]; bus24.b = qb[2];
            end else if (k == 1) begin
                bus24.start = 1'b0;
            end
        end
        check("b2b_gap01", 64'(t_done[1] - t_done[0]), 64'd26);
        check("b2b_gap12", 64'(t_done[2] - t_done[1]), 64'd26);
        check("b2b_idle_after", 64'(bus24.busy), 64'd0);

        // Operand change and start pulse while busy must be ignored
        prev = 64'(bus24.product);
        @(negedge clk);
        bus24.start = 1'b1; bus24.a = 24'hC0FFEE; bus24.b = 24'h00BEEF;
        @(posedge clk);
        @(negedge clk);
        bus24.start = 1'b0;
        lat = 0;
        while (!bus24.done && lat < 100) begin
            if (lat == 5) begin
                check("busy_prod_hold", 64'(bus24.product), prev);
                bus24.start = 1'b1; bus24.a = 24'h123123; bus24.b = 24'h777777;
            end else begin
                bus24.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus24.start = 1'b0;
        check("ignore_prod", 64'(bus24.product), 64'(24'hC0FFEE) * 64'(24'h00BEEF));
        check("ignore_lat", 64'(lat), 64'd25);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus24.done) dn++;
        end
        check("ignore_no_extra_done", 64'(dn), 64'd0);

        // Reset mid-accumulation aborts the operation
        @(negedge clk);
        bus24.start = 1'b1; bus24.a = 24'h5A5A5A; bus24.b = 24'hA5A5A5;
        @(posedge clk);
        @(negedge clk);
        bus24.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus24.busy), 64'd0);
        check("abort_done", 64'(bus24.done), 64'd0);
        check("abort_product", 64'(bus24.product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus24.done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        op24(24'h5A5A5A, 24'hA5A5A5, p, lat, bn);
        check("after_abort_prod", p, 64'(24'h5A5A5A) * 64'(24'hA5A5A5));
        check("after_abort_lat", 64'(lat), 64'd25);

        // Random regression on all three widths in parallel
        fork
            rand24(300);
            rand11(600);
            rand4(1500);
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
